// File: rtl/kercol_accum.sv
// Kernel-column accumulator: sums NO_COL_KERNEL product columns per lane into one window
// and presents the finished window through a single-entry valid/ready output slot.

module kercol_lane #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 19
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IN_W-1:0]  i_lane,
    input  logic             i_first,
    input  logic             i_add,
    input  logic             i_load_out,
    output logic [ACC_W-1:0] o_acc
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] lane_ext;
    logic [ACC_W-1:0] sum;

    assign lane_ext = ACC_W'(i_lane);
    assign sum      = acc + lane_ext;

    // The final beat's sum goes straight to the output slot; acc is don't-care afterwards.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc   <= '0;
            o_acc <= '0;
        end else begin
            if (i_first)
                acc <= lane_ext;
            else if (i_add)
                acc <= sum;
            if (i_load_out)
                o_acc <= sum;
        end
    end
endmodule

module kercol_accum #(
    parameter int BIT_WIDTH     = 8,
    parameter int NO_COL_KERNEL = 5,
    parameter int ACC_WIDTH     = 2*BIT_WIDTH+3
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic [NO_COL_KERNEL-1:0][2*BIT_WIDTH-1:0]     i_feature_map_col,
    input  logic [2:0]                                    i_kercol_cnt,
    input  logic                                          i_valid,
    input  logic                                          i_start,
    output logic [NO_COL_KERNEL-1:0][ACC_WIDTH-1:0]       o_acc_col,
    output logic                                          o_out_valid,
    input  logic                                          i_out_ready,
    output logic [15:0]                                   o_win_cnt,
    output logic                                          o_seq_err,
    output logic                                          o_overflow
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic [2:0] LAST = 3'(NO_COL_KERNEL-1);

    state_t     state;
    logic [2:0] exp_col;
    logic       start_req, start_beat, err_beat, mid_beat, fin_beat;
    logic       deliver, slot_free, load_out;

    // Start beats win over sequencing: a restart silently drops any partial window.
    always_comb begin
        start_req  = i_valid & (i_start | (state == IDLE));
        start_beat = start_req & (i_kercol_cnt == 3'd0);
        err_beat   = i_valid & (start_req ? (i_kercol_cnt != 3'd0) : (i_kercol_cnt != exp_col));
        fin_beat   = i_valid & ~start_req & (i_kercol_cnt == exp_col) & (exp_col == LAST);
        mid_beat   = i_valid & ~start_req & (i_kercol_cnt == exp_col) & (exp_col != LAST);
        deliver    = o_out_valid & i_out_ready;
        slot_free  = ~o_out_valid | i_out_ready;
        load_out   = fin_beat & slot_free;
    end

    genvar k;
    generate
        for (k = 0; k < NO_COL_KERNEL; k++) begin : g_lane
            kercol_lane #(
                .IN_W  (2*BIT_WIDTH),
                .ACC_W (ACC_WIDTH)
            ) u_lane (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_lane     (i_feature_map_col[k]),
                .i_first    (start_beat),
                .i_add      (mid_beat),
                .i_load_out (load_out),
                .o_acc      (o_acc_col[k])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            exp_col     <= 3'd0;
            o_out_valid <= 1'b0;
            o_win_cnt   <= 16'd0;
            o_seq_err   <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            if (start_beat) begin
                state   <= ACCUM;
                exp_col <= 3'd1;
            end else if (err_beat | fin_beat) begin
                state   <= IDLE;
                exp_col <= 3'd0;
            end else if (mid_beat) begin
                exp_col <= 3'(exp_col + 3'd1);
            end

            if (err_beat)
                o_seq_err <= 1'b1;
            if (fin_beat & ~slot_free)
                o_overflow <= 1'b1;
            if (deliver)
                o_win_cnt <= o_win_cnt + 16'd1;

            // A reload in the draining cycle keeps the slot full without a bubble.
            if (load_out)
                o_out_valid <= 1'b1;
            else if (deliver)
                o_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_kercol_accum.sv
// Bench for kercol_accum: directed scenarios with fixed expectations plus a randomized
// run checked every cycle against a window-level reference model.
`timescale 1ns/1ps

module tb_kercol_accum;
    localparam int BW = 8;
    localparam int N  = 5;
    localparam int LW = 2*BW;
    localparam int AW = 2*BW+3;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic [N-1:0][LW-1:0]   col;
    logic [2:0]             kcnt;
    logic                   vld, st, rdy;
    logic [N-1:0][AW-1:0]   acc_col;
    logic                   out_valid;
    logic [15:0]            win_cnt;
    logic                   seq_err, overflow;

    int total = 0;
    int bad   = 0;

    kercol_accum #(.BIT_WIDTH(BW), .NO_COL_KERNEL(N), .ACC_WIDTH(AW)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_feature_map_col (col),
        .i_kercol_cnt      (kcnt),
        .i_valid           (vld),
        .i_start           (st),
        .o_acc_col         (acc_col),
        .o_out_valid       (out_valid),
        .i_out_ready       (rdy),
        .o_win_cnt         (win_cnt),
        .o_seq_err         (seq_err),
        .o_overflow        (overflow)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: keeps the raw columns of the open window and sums them at the end.
    int                    m_exp;
    logic [N-1:0][LW-1:0]  m_cols[$];
    logic                  m_valid;
    logic [N-1:0][AW-1:0]  m_data;
    logic [15:0]           m_cnt;
    logic                  m_err, m_ovf;

    task automatic model_reset();
        m_exp = 0; m_cols.delete(); m_valid = 0; m_data = '0;
        m_cnt = 0; m_err = 0; m_ovf = 0;
    endtask

    task automatic model_edge();
        bit fin;
        logic [N-1:0][AW-1:0] sums;
        fin  = 0;
        sums = '0;
        if (vld) begin
            if ((st || m_exp == 0) && kcnt == 0) begin
                m_cols.delete(); m_cols.push_back(col); m_exp = 1;
            end else if (st || m_exp == 0 || int'(kcnt) != m_exp) begin
                m_err = 1; m_exp = 0; m_cols.delete();
            end else begin
                m_cols.push_back(col);
                if (m_exp == N-1) begin
                    fin = 1;
                    foreach (m_cols[c])
                        for (int k = 0; k < N; k++) sums[k] += AW'(m_cols[c][k]);
                    m_exp = 0; m_cols.delete();
                end else m_exp++;
            end
        end
        if (m_valid && rdy) begin m_cnt++; m_valid = 0; end
        if (fin) begin
            if (!m_valid) begin m_valid = 1; m_data = sums; end
            else m_ovf = 1;
        end
    endtask

    function automatic logic [N-1:0][LW-1:0] fill(input logic [LW-1:0] v);
        logic [N-1:0][LW-1:0] r;
        for (int k = 0; k < N; k++) r[k] = v;
        return r;
    endfunction

    task automatic cycle(input bit v, input bit s, input int c,
                         input logic [N-1:0][LW-1:0] d, input bit r);
        vld = v; st = s; kcnt = 3'(c); col = d; rdy = r;
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        vld = 0; st = 0; kcnt = 0; col = '0; rdy = 0;
        i_rst = 1;
        @(posedge i_clk);
        #1;
        i_rst = 0;
        model_reset();
    endtask

    // Five beats 0..N-1 with start on beat 0; r_last is ready on the final beat.
    task automatic send_win(input logic [LW-1:0] v, input bit r_other, input bit r_last);
        for (int b = 0; b < N; b++)
            cycle(1, b == 0, b, fill(v), (b == N-1) ? r_last : r_other);
    endtask

    task automatic test_reset();
        vld = 0; st = 0; kcnt = 0; col = '0; rdy = 0;
        i_rst = 1;
        #12;
        total++;
        if ({acc_col, out_valid, win_cnt, seq_err, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_state got acc=%0h v=%0b cnt=%0d err=%0b ovf=%0b want all 0",
                     acc_col, out_valid, win_cnt, seq_err, overflow);
        end
        @(posedge i_clk); #1;
        i_rst = 0;
        model_reset();
    endtask

    task automatic test_basic();
        do_reset();
        send_win(16'h000A, 1, 1);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b want=1", out_valid); end
        for (int k = 0; k < N; k++) begin
            total++;
            if (acc_col[k] !== AW'(32'h32)) begin
                bad++; $display("FAIL basic_lane%0d got=%0h want=32", k, acc_col[k]);
            end
        end
        cycle(0, 0, 0, '0, 1);
        total++;
        if (out_valid !== 1'b0 || win_cnt !== 16'd1) begin
            bad++; $display("FAIL basic_pulse got v=%0b cnt=%0d want v=0 cnt=1", out_valid, win_cnt);
        end
    endtask

    task automatic test_max();
        do_reset();
        send_win(16'hFE01, 1, 1);
        for (int k = 0; k < N; k++) begin
            total++;
            if (acc_col[k] !== AW'(32'h4F605)) begin
                bad++; $display("FAIL max_lane%0d got=%0h want=4f605", k, acc_col[k]);
            end
        end
        total++;
        if (out_valid !== 1'b1 || seq_err !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL max_flags got v=%0b err=%0b ovf=%0b want 1 0 0", out_valid, seq_err, overflow);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_win(16'h0003, 0, 0);
        send_win(16'h0100, 0, 0);
        total++;
        if (out_valid !== 1'b1 || overflow !== 1'b1 || acc_col[0] !== AW'(32'hF)) begin
            bad++; $display("FAIL bp_hold got v=%0b ovf=%0b lane0=%0h want v=1 ovf=1 lane0=f",
                            out_valid, overflow, acc_col[0]);
        end
        cycle(0, 0, 0, '0, 1);
        total++;
        if (out_valid !== 1'b0 || win_cnt !== 16'd1) begin
            bad++; $display("FAIL bp_deliver got v=%0b cnt=%0d want v=0 cnt=1", out_valid, win_cnt);
        end
    endtask

    task automatic test_drain_reload();
        do_reset();
        send_win(16'h0003, 0, 0);
        send_win(16'h0007, 0, 1);
        total++;
        if (out_valid !== 1'b1 || win_cnt !== 16'd1 || overflow !== 1'b0) begin
            bad++; $display("FAIL reload_ctl got v=%0b cnt=%0d ovf=%0b want v=1 cnt=1 ovf=0",
                            out_valid, win_cnt, overflow);
        end
        for (int k = 0; k < N; k++) begin
            total++;
            if (acc_col[k] !== AW'(32'h23)) begin
                bad++; $display("FAIL reload_lane%0d got=%0h want=23", k, acc_col[k]);
            end
        end
        cycle(0, 0, 0, '0, 1);
        total++;
        if (out_valid !== 1'b0 || win_cnt !== 16'd2) begin
            bad++; $display("FAIL reload_drain got v=%0b cnt=%0d want v=0 cnt=2", out_valid, win_cnt);
        end
    endtask

    task automatic test_seq_err();
        do_reset();
        cycle(1, 1, 0, fill(16'h0005), 1);
        cycle(1, 0, 1, fill(16'h0005), 1);
        total++;
        if (seq_err !== 1'b0) begin bad++; $display("FAIL seq_early got=%0b want=0", seq_err); end
        cycle(1, 0, 3, fill(16'h0005), 1);
        total++;
        if (seq_err !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL seq_err got err=%0b v=%0b want err=1 v=0", seq_err, out_valid);
        end
        cycle(1, 0, 4, fill(16'h0005), 1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL seq_no_window got v=%0b want=0", out_valid); end
        send_win(16'h0004, 1, 1);
        total++;
        if (out_valid !== 1'b1 || acc_col[N-1] !== AW'(32'h14) || seq_err !== 1'b1) begin
            bad++; $display("FAIL seq_recover got v=%0b lane=%0h err=%0b want v=1 lane=14 err=1",
                            out_valid, acc_col[N-1], seq_err);
        end
    endtask

    task automatic test_restart();
        do_reset();
        cycle(1, 1, 0, fill(16'h0009), 1);
        cycle(1, 0, 1, fill(16'h0009), 1);
        send_win(16'h000A, 1, 1);
        total++;
        if (out_valid !== 1'b1 || acc_col[2] !== AW'(32'h32) || seq_err !== 1'b0) begin
            bad++; $display("FAIL restart got v=%0b lane=%0h err=%0b want v=1 lane=32 err=0",
                            out_valid, acc_col[2], seq_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_win(16'h0002, 0, 0);
        cycle(1, 0, 3, fill(16'h0001), 0);
        cycle(1, 1, 0, fill(16'h0001), 0);
        cycle(1, 0, 1, fill(16'h0001), 0);
        #2;
        i_rst = 1;
        #1;
        total++;
        if ({acc_col, out_valid, win_cnt, seq_err, overflow} !== '0) begin
            bad++; $display("FAIL async_reset got v=%0b lane0=%0h err=%0b want all 0",
                            out_valid, acc_col[0], seq_err);
        end
        model_reset();
        vld = 0;
        @(posedge i_clk); #1;
        i_rst = 0;
        send_win(16'h0011, 1, 1);
        total++;
        if (out_valid !== 1'b1 || acc_col[1] !== AW'(32'h55)) begin
            bad++; $display("FAIL post_reset_win got v=%0b lane=%0h want v=1 lane=55", out_valid, acc_col[1]);
        end
        cycle(0, 0, 0, '0, 1);
        total++;
        if (win_cnt !== 16'd1) begin bad++; $display("FAIL post_reset_cnt got=%0d want=1", win_cnt); end
    endtask

    task automatic test_random();
        logic [N-1:0][LW-1:0] d;
        int c;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) do_reset();
            for (int k = 0; k < N; k++) d[k] = LW'($urandom);
            c = ($urandom_range(0, 19) == 0) ? $urandom_range(0, N-1) : m_exp;
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0, c, d, $urandom_range(0, 9) < 6);
            total++;
            if (out_valid !== m_valid || win_cnt !== m_cnt || seq_err !== m_err || overflow !== m_ovf) begin
                bad++; $display("FAIL rand_ctl cyc=%0d got v=%0b cnt=%0d err=%0b ovf=%0b want v=%0b cnt=%0d err=%0b ovf=%0b",
                                i, out_valid, win_cnt, seq_err, overflow, m_valid, m_cnt, m_err, m_ovf);
            end
            total++;
            if (acc_col !== m_data) begin
                bad++; $display("FAIL rand_data cyc=%0d got=%0h want=%0h", i, acc_col, m_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_backpressure();
        test_drain_reload();
        test_seq_err();
        test_restart();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end
endmodule
